// File: rtl/shiftreg_send_data.sv
// Serialises a parallel word into the on-chip shift register, MSB- or LSB-first,
// then strobes load and pulses done.
//
// Ports:
//   clk      : control clock, rising edge
//   rst      : synchronous active-high reset
//   start    : transfer request, sampled only while idle
//   din      : parallel word, captured on the edge that accepts start
//   data_out : serial data to the shift-register input
//   clk_en   : shift-clock gate, high exactly while data_out is valid
//   load     : latch strobe to the holding register
//   busy     : high whenever a transfer is in progress
//   done     : one-cycle completion pulse
module shiftreg_send_data #(
    parameter int DATA_WIDTH       = 170,
    parameter int CNT_WIDTH        = 8,
    parameter int SHIFT_DIRECTION  = 1,
    parameter int LOAD_PULSE_WIDTH = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] din,
    output logic                  data_out,
    output logic                  clk_en,
    output logic                  load,
    output logic                  busy,
    output logic                  done
);

    localparam int CW = CNT_WIDTH + 1;
    localparam int LW = (LOAD_PULSE_WIDTH > 1) ?
                        $clog2(LOAD_PULSE_WIDTH + 1) : 1;

    localparam logic [CW-1:0] C_LAST = CW'(DATA_WIDTH);
    localparam logic [CW-1:0] C_ONE  = CW'(1);
    localparam logic [LW-1:0] L_LAST = LW'(LOAD_PULSE_WIDTH);
    localparam logic [LW-1:0] L_ONE  = LW'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_LOAD,
        S_DONE
    } state_t;

    state_t                r_state;
    logic [DATA_WIDTH-1:0] r_shreg;
    logic [CW-1:0]         r_cnt;
    logic [LW-1:0]         r_lcnt;
    logic                  r_data_out;
    logic                  r_clk_en;
    logic                  r_load;
    logic                  r_busy;
    logic                  r_done;

    logic [DATA_WIDTH-1:0] w_shift_nxt;
    logic                  w_next_bit;
    logic                  w_first_bit;

    // The output end of shreg always holds the bit currently on data_out,
    // so the next bit is the output end of the shifted word.
    always_comb begin
        w_shift_nxt = '0;
        w_next_bit  = 1'b0;
        w_first_bit = 1'b0;
        if (SHIFT_DIRECTION != 0) begin
            w_shift_nxt = r_shreg << 1;
            w_next_bit  = w_shift_nxt[DATA_WIDTH-1];
            w_first_bit = din[DATA_WIDTH-1];
        end else begin
            w_shift_nxt = r_shreg >> 1;
            w_next_bit  = w_shift_nxt[0];
            w_first_bit = din[0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_shreg    <= '0;
            r_cnt      <= '0;
            r_lcnt     <= '0;
            r_data_out <= 1'b0;
            r_clk_en   <= 1'b0;
            r_load     <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    r_data_out <= 1'b0;
                    r_clk_en   <= 1'b0;
                    r_load     <= 1'b0;
                    r_busy     <= 1'b0;
                    r_done     <= 1'b0;
                    if (start) begin
                        r_shreg    <= din;
                        r_data_out <= w_first_bit;
                        r_clk_en   <= 1'b1;
                        r_busy     <= 1'b1;
                        r_cnt      <= C_ONE;
                        r_state    <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    if (r_cnt < C_LAST) begin
                        r_shreg    <= w_shift_nxt;
                        r_data_out <= w_next_bit;
                        r_cnt      <= r_cnt + C_ONE;
                    end else begin
                        r_clk_en   <= 1'b0;
                        r_data_out <= 1'b0;
                        if (LOAD_PULSE_WIDTH > 0) begin
                            r_load  <= 1'b1;
                            r_lcnt  <= L_ONE;
                            r_state <= S_LOAD;
                        end else begin
                            r_done  <= 1'b1;
                            r_state <= S_DONE;
                        end
                    end
                end
                S_LOAD: begin
                    if (r_lcnt == L_LAST) begin
                        r_load  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_lcnt <= r_lcnt + L_ONE;
                    end
                end
                S_DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_cnt   <= '0;
                    r_lcnt  <= '0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign data_out = r_data_out;
    assign clk_en   = r_clk_en;
    assign load     = r_load;
    assign busy     = r_busy;
    assign done     = r_done;

endmodule

// File: tb/tb_shiftreg_send_data.sv
// Testbench for shiftreg_send_data: three parameterisations against a
// transfer-timeline reference model, plus vector tables and corner sequences.
module tb_shiftreg_send_data;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [2:0] st = '0;
    logic [7:0]   d0 = '0;
    logic [7:0]   d1 = '0;
    logic [169:0] d2 = '0;
    logic [2:0] o_do, o_ce, o_ld, o_bz, o_dn;

    int checks = 0;
    int failures = 0;
    bit mon_on = 1'b0;

    always #5 clk = ~clk;

    shiftreg_send_data #(
        .DATA_WIDTH(8), .CNT_WIDTH(3),
        .SHIFT_DIRECTION(1), .LOAD_PULSE_WIDTH(2)
    ) u_msb (
        .clk(clk), .rst(rst), .start(st[0]), .din(d0),
        .data_out(o_do[0]), .clk_en(o_ce[0]), .load(o_ld[0]),
        .busy(o_bz[0]), .done(o_dn[0])
    );

    shiftreg_send_data #(
        .DATA_WIDTH(8), .CNT_WIDTH(3),
        .SHIFT_DIRECTION(0), .LOAD_PULSE_WIDTH(0)
    ) u_lsb (
        .clk(clk), .rst(rst), .start(st[1]), .din(d1),
        .data_out(o_do[1]), .clk_en(o_ce[1]), .load(o_ld[1]),
        .busy(o_bz[1]), .done(o_dn[1])
    );

    shiftreg_send_data u_full (
        .clk(clk), .rst(rst), .start(st[2]), .din(d2),
        .data_out(o_do[2]), .clk_en(o_ce[2]), .load(o_ld[2]),
        .busy(o_bz[2]), .done(o_dn[2])
    );

    // Reference model: position within the transfer timeline (0 = idle).
    int PW[3] = '{8, 8, 170};
    int PL[3] = '{2, 0, 2};
    bit PS[3] = '{1'b1, 1'b0, 1'b1};
    int mpos[3] = '{0, 0, 0};
    logic [169:0] mword[3];

    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (rst) begin
                mpos[i] <= 0;
            end else if (mpos[i] == 0) begin
                if (st[i]) begin
                    mpos[i] <= 1;
                    mword[i] <= (i == 0) ? {162'b0, d0} :
                                (i == 1) ? {162'b0, d1} : d2;
                end
            end else begin
                mpos[i] <= (mpos[i] == PW[i] + PL[i] + 1) ? 0 : mpos[i] + 1;
            end
        end
    end

    // Chip-side shift register and capture path on the MSB-first DUT.
    logic [7:0] chip_sr = '0;
    logic [7:0] cap = '0;
    always @(posedge clk) begin
        if (rst) begin
            chip_sr <= '0;
            cap <= '0;
        end else if (o_ce[0]) begin
            cap <= {cap[6:0], chip_sr[7]};
            chip_sr <= {chip_sr[6:0], o_do[0]};
        end
    end

    // {data_out, clk_en, load, busy, done}
    function automatic logic [4:0] exp_out(input int pos,
                                           input logic [169:0] w,
                                           input int W, input int L,
                                           input bit sd);
        logic [4:0] e;
        e = '0;
        if (pos > 0) begin
            e[1] = 1'b1;
            if (pos <= W) begin
                e[3] = 1'b1;
                e[4] = sd ? w[W-pos] : w[pos-1];
            end else if (pos <= W + L) begin
                e[2] = 1'b1;
            end else begin
                e[0] = 1'b1;
            end
        end
        return e;
    endfunction

    task automatic chk(input string name, input logic [169:0] got,
                       input logic [169:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s got=%0h want=%0h", name, got, want);
        end
    endtask

    task automatic mon();
        logic [4:0] a, e;
        for (int i = 0; i < 3; i++) begin
            a = {o_do[i], o_ce[i], o_ld[i], o_bz[i], o_dn[i]};
            e = exp_out(mpos[i], mword[i], PW[i], PL[i], PS[i]);
            checks++;
            if (a !== e) begin
                failures++;
                $display("FAIL model dut%0d pos=%0d got=%b want=%b t=%0t",
                         i, mpos[i], a, e, $time);
            end
        end
    endtask

    task automatic xfer(input int s, input logic [169:0] d,
                        input int ncyc,
                        output logic [169:0] strm, output int ncl,
                        output int nld, output int fld,
                        output int dcy, output int nbz);
        strm = '0; ncl = 0; nld = 0; fld = 0; dcy = 0; nbz = 0;
        @(negedge clk);
        st[s] = 1'b1;
        if (s == 0) d0 = d[7:0];
        else if (s == 1) d1 = d[7:0];
        else d2 = d;
        @(negedge clk);
        st[s] = 1'b0;
        for (int k = 1; k <= ncyc; k++) begin
            if (o_ce[s]) begin
                strm = {strm[168:0], o_do[s]};
                ncl++;
            end
            if (o_ld[s]) begin
                nld++;
                if (fld == 0) fld = k;
            end
            if (o_dn[s] && dcy == 0) dcy = k;
            if (o_bz[s]) nbz++;
            @(negedge clk);
        end
    endtask

    typedef struct {
        int         s;
        logic [7:0] din;
        logic [7:0] strm;
        int         nld;
        int         fld;
        int         dcy;
        int         nbz;
    } vec_t;

    vec_t tbl[6];

    initial begin
        logic [169:0] sv, wd;
        logic [7:0] s1, s2, rv;
        int ncl, nld, fld, dcy, nbz, bad, ndn, dc1, dc2;

        tbl[0] = '{0, 8'hA5, 8'hA5, 2, 9, 11, 11};
        tbl[1] = '{0, 8'h3C, 8'h3C, 2, 9, 11, 11};
        tbl[2] = '{0, 8'h80, 8'h80, 2, 9, 11, 11};
        tbl[3] = '{1, 8'h01, 8'h80, 0, 0, 9, 9};
        tbl[4] = '{1, 8'h0F, 8'hF0, 0, 0, 9, 9};
        tbl[5] = '{1, 8'h12, 8'h48, 0, 0, 9, 9};

        fork
            forever begin
                @(negedge clk);
                if (mon_on) mon();
            end
        join_none

        @(negedge clk);
        @(negedge clk);
        for (int i = 0; i < 3; i++)
            chk($sformatf("reset_dut%0d", i),
                {165'b0, o_do[i], o_ce[i], o_ld[i], o_bz[i], o_dn[i]}, '0);
        mon_on = 1'b1;
        rst = 1'b0;

        foreach (tbl[i]) begin
            xfer(tbl[i].s, {162'b0, tbl[i].din}, 12,
                 sv, ncl, nld, fld, dcy, nbz);
            chk($sformatf("tbl%0d_stream", i), sv, {162'b0, tbl[i].strm});
            chk($sformatf("tbl%0d_clken", i), ncl, 8);
            chk($sformatf("tbl%0d_nload", i), nld, tbl[i].nld);
            chk($sformatf("tbl%0d_fload", i), fld, tbl[i].fld);
            chk($sformatf("tbl%0d_done", i), dcy, tbl[i].dcy);
            chk($sformatf("tbl%0d_busy", i), nbz, tbl[i].nbz);
        end

        for (int r = 0; r < 6; r++) begin
            wd = {162'b0, 8'($urandom)};
            xfer(r % 2, wd, 12, sv, ncl, nld, fld, dcy, nbz);
            for (int b = 0; b < 8; b++) rv[b] = wd[7-b];
            chk($sformatf("rand%0d_stream", r), sv,
                (r % 2 == 0) ? wd : {162'b0, rv});
        end

        for (int j = 0; j < 6; j++) wd[j*32 +: 32] = $urandom;
        wd[169:160] = 10'($urandom);
        xfer(2, wd, 176, sv, ncl, nld, fld, dcy, nbz);
        chk("full_clken", ncl, 170);
        chk("full_stream", sv, wd);
        chk("full_done", dcy, 173);
        chk("full_busy", nbz, 173);

        // start held high, din changed during the first transfer
        @(negedge clk);
        st[0] = 1'b1;
        d0 = 8'hA5;
        @(negedge clk);
        s1 = '0; s2 = '0; dc1 = 0; dc2 = 0;
        for (int k = 1; k <= 24; k++) begin
            if (o_ce[0]) begin
                if (k <= 8) s1 = {s1[6:0], o_do[0]};
                else s2 = {s2[6:0], o_do[0]};
            end
            if (o_dn[0]) begin
                if (dc1 == 0) dc1 = k;
                else dc2 = k;
            end
            if (k == 5) d0 = 8'hC3;
            if (k == 13) st[0] = 1'b0;
            @(negedge clk);
        end
        chk("hold_first", s1, 8'hA5);
        chk("hold_second", s2, 8'hC3);
        chk("hold_done1", dc1, 11);
        chk("hold_done2", dc2, 23);

        // reset at cycle 4 of an 8-bit transfer
        @(negedge clk);
        st[0] = 1'b1;
        d0 = 8'h96;
        @(negedge clk);
        st[0] = 1'b0;
        bad = 0; nld = 0; ndn = 0; ncl = 0;
        for (int k = 1; k <= 15; k++) begin
            if (k >= 5 && (o_ce[0] || o_ld[0] || o_dn[0] ||
                           o_bz[0] || o_do[0])) bad++;
            if (o_ce[0]) ncl++;
            if (o_ld[0]) nld++;
            if (o_dn[0]) ndn++;
            if (k == 4) rst = 1'b1;
            if (k == 5) rst = 1'b0;
            @(negedge clk);
        end
        chk("rst_quiet", bad, 0);
        chk("rst_clken", ncl, 4);
        chk("rst_noload", nld, 0);
        chk("rst_nodone", ndn, 0);
        xfer(0, {162'b0, 8'h69}, 12, sv, ncl, nld, fld, dcy, nbz);
        chk("rst_after_stream", sv, {162'b0, 8'h69});
        chk("rst_after_done", dcy, 11);

        // loopback through the chip shift register
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        xfer(0, {162'b0, 8'hA5}, 12, sv, ncl, nld, fld, dcy, nbz);
        xfer(0, {162'b0, 8'h3C}, 12, sv, ncl, nld, fld, dcy, nbz);
        chk("loop_capture", cap, 8'hA5);
        chk("loop_chip", chip_sr, 8'h3C);

        mon_on = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/shiftreg_send_data.md
# shiftreg_send_data

Serialises a parallel configuration word into the TMIIa on-chip shift register, one bit per `clk` cycle, and gates the shift clock only while valid bits are presented. It is the write-side counterpart of the shift-register capture path: a start pulse loads the word, the bits stream out MSB-first or LSB-first, and a latch pulse transfers the shifted word into the chip's holding register. The block sits between the register-control logic, which provides `din` and `start`, and the chip pins `data_out`, `clk_en` and `load`. The capture path can run on the same `start` to read back the previous contents.

## Interface
- `DATA_WIDTH`, default 170, is the number of bits shifted per transfer. Legal range is 1 to 2^(CNT_WIDTH+1)-1.
- `CNT_WIDTH`, default 8. The internal bit counter is CNT_WIDTH+1 bits wide.
- `SHIFT_DIRECTION`, default 1. When 1, `din[DATA_WIDTH-1]` is shifted first. When 0, `din[0]` is shifted first.
- `LOAD_PULSE_WIDTH`, default 2, is the number of cycles `load` is held high after the last bit. A value of 0 skips the LOAD state entirely.

Ports:
- `clk`, input, 1 bit: the control clock. All logic is clocked on its rising edge.
- `rst`, input, 1 bit: reset, synchronous and active-high.
- `start`, input, 1 bit: transfer request. It is sampled only in IDLE.
- `din`, input, DATA_WIDTH bits: the parallel word. It is captured on the edge that accepts `start`.
- `data_out`, output, 1 bit: serial data to the shift-register input.
- `clk_en`, output, 1 bit: shift-clock gate. It is high exactly while `data_out` carries a valid bit.
- `load`, output, 1 bit: latch strobe to the chip's holding register.
- `busy`, output, 1 bit: high whenever the state is not IDLE.
- `done`, output, 1 bit: a one-cycle pulse when a transfer completes.

## Operation
- **Registers.**
  - A state register holds one of IDLE, SHIFT, LOAD or DONE.
  - The shift register `shreg` is DATA_WIDTH bits wide.
  - The bit counter `cnt` is CNT_WIDTH+1 bits wide.
  - A load counter is sized to hold LOAD_PULSE_WIDTH.
  - All outputs are registered.
- **IDLE.**
  - Outputs are 0.
  - If `start`=1: capture `shreg<=din`, set `data_out` to the first bit, set `clk_en<=1`, set `cnt<=1`, and go to SHIFT.
- **SHIFT.**
  - Each edge with `cnt<DATA_WIDTH`:
    - shift `shreg` toward the output end (left if SHIFT_DIRECTION=1, right otherwise);
    - drive the next bit on `data_out`;
    - increment `cnt`.
  - The edge with `cnt==DATA_WIDTH` does the following:
    - set `clk_en<=0` and `data_out<=0`;
    - if LOAD_PULSE_WIDTH>0, go to LOAD with `load<=1`;
    - otherwise go to DONE with `done<=1`.
- **LOAD.**
  - `load` stays high for exactly LOAD_PULSE_WIDTH cycles.
  - Then go to DONE: `load<=0`, `done<=1`.
- **DONE.** Lasts one cycle. `done` is high. The next state is IDLE.
- **Ignored inputs.**
  - `start` is ignored in SHIFT, LOAD and DONE; no request is queued.
  - Changes on `din` after capture have no effect on the transfer in progress.
- **Reset.**
  - An `rst`=1 sampled at any edge forces the state to IDLE, clears `shreg`, both counters and all outputs, and overrides `start`.
  - A reset mid-transfer aborts the transfer: no `load` and no `done` are issued.

## Timing
- Let start be accepted at edge 0, with W=DATA_WIDTH and L=LOAD_PULSE_WIDTH.
- **Shift phase.**
  - `data_out` and `clk_en` are valid from edge 0 through edge W.
  - This covers cycles 1..W; each bit is held one full period.
  - Bit k (1-based) appears in cycle k.
- **Load phase.**
  - `load` is high during cycles W+1..W+L.
  - `data_out` and `clk_en` are 0 in these cycles.
- **Completion.**
  - `done` is high in cycle W+L+1.
  - `busy` is high in cycles 1..W+L+1.
- **Restart.** A new `start` is first accepted at edge W+L+2. Back-to-back transfers have a period of W+L+2 cycles.
- **Off-phase values.** `clk_en`, `load` and `done` are never high outside their phases. `data_out` is 0 whenever `clk_en` is 0.
- **Reset values.** `data_out`=0, `clk_en`=0, `load`=0, `busy`=0, `done`=0.

## Test plan
- **Basic MSB-first transfer.** DATA_WIDTH=8, SHIFT_DIRECTION=1, L=2, `din`=8'hA5, `start` pulsed for 1 cycle. Required response:
  - `data_out` carries 1,0,1,0,0,1,0,1 in cycles 1..8;
  - `clk_en` is high for exactly 8 cycles;
  - `load` is high in cycles 9..10;
  - `done` is high in cycle 11;
  - `busy` is high in cycles 1..11.
- **LSB-first, no load pulse.** SHIFT_DIRECTION=0, L=0, `din`=8'h01. Required response: `data_out` is 1 in cycle 1 and 0 in cycles 2..8; `load` never rises; `done` is high in cycle 9.
- **Full-width word.** DATA_WIDTH=170, `din` is random. Required response:
  - `clk_en` is high for exactly 170 cycles;
  - the serial stream, reassembled MSB-first, equals `din`;
  - `done` is high in cycle 173.
- **Start and din changes while busy.** Hold `start`=1 continuously and change `din` during SHIFT. Required response:
  - the first word is sent unchanged;
  - the second transfer begins at edge W+L+2 using `din` as sampled at that edge.
- **Reset mid-shift.** Assert `rst` for 1 cycle at cycle 4 of 8. Required response:
  - all outputs are 0 from the next cycle;
  - no `load` and no `done` occur;
  - a subsequent `start` runs a complete, correct transfer.
- **Loopback with the capture block.** Loop `data_out` back to the capture block's `data_in` (a clean 1-bit shift-register model). Required response: after two transfers, the captured word equals the first `din`.
